// File: rtl/axi4lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register responder.
// Response codes, channel FSM states and the byte-strobe merge used by the register bank.
package axi4lite_pkg;

  localparam int ADDR_LSB = 2;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4lite_reg_bank.sv
// Register array with a byte-strobe write port, one combinational read port and
// per-register write pulses that trail each write by one cycle.
module axi4lite_reg_bank
  import axi4lite_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_strb,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_r;
  logic [DATA_W-1:0]   rd_data_s;

  // Register storage and write pulses; an index outside the array matches no entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
      wr_pulse_r <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          regs_r[i]     <= apply_strb(regs_r[i], wr_data, wr_strb);
          wr_pulse_r[i] <= 1'b1;
        end else begin
          wr_pulse_r[i] <= 1'b0;
        end
      end
    end
  end

  // Read mux returns the value held before any write landing on the same edge.
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data_s = regs_r[i];
      end else begin
        rd_data_s = rd_data_s;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*DATA_W +: DATA_W] = regs_r[g];
  end

  assign rd_data  = rd_data_s;
  assign wr_pulse = wr_pulse_r;

endmodule

// File: rtl/axi4lite_reg_responder.sv
// AXI4-Lite responder exposing NUM_REGS registers to fabric logic.
// Independent write and read FSMs; the write side latches AW and W separately.
module axi4lite_reg_responder
  import axi4lite_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_W-1:0]          S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int IDX_W = ADDR_W - ADDR_LSB;

  wr_state_t             wr_state_r, wr_state_nx_s;
  logic                  aw_lat_r, aw_lat_nx_s;
  logic [IDX_W-1:0]      aw_idx_r, aw_idx_nx_s;
  logic                  w_lat_r, w_lat_nx_s;
  logic [DATA_W-1:0]     w_data_r, w_data_nx_s;
  logic [DATA_W/8-1:0]   w_strb_r, w_strb_nx_s;
  logic                  awready_r, awready_nx_s;
  logic                  wready_r, wready_nx_s;
  logic                  bvalid_r, bvalid_nx_s;
  resp_t                 bresp_r, bresp_nx_s;
  logic                  commit_s;

  rd_state_t             rd_state_r, rd_state_nx_s;
  logic                  arready_r, arready_nx_s;
  logic                  rvalid_r, rvalid_nx_s;
  resp_t                 rresp_r, rresp_nx_s;
  logic [DATA_W-1:0]     rdata_r, rdata_nx_s;

  logic                  aw_hs_s, w_hs_s, ar_hs_s;
  logic                  wr_in_range_s, rd_in_range_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic [DATA_W-1:0]     bank_rd_data_s;
  logic                  unused_s;

  assign aw_hs_s       = awready_r & S_AXI_AWVALID;
  assign w_hs_s        = wready_r & S_AXI_WVALID;
  assign ar_hs_s       = arready_r & S_AXI_ARVALID;
  assign rd_idx_s      = S_AXI_ARADDR[ADDR_W-1:ADDR_LSB];
  assign wr_in_range_s = (32'(aw_idx_r) < 32'(NUM_REGS));
  assign rd_in_range_s = (32'(rd_idx_s) < 32'(NUM_REGS));
  assign unused_s      = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Write FSM: latch AW and W independently, commit once both are held, then hold B.
  always_comb begin
    wr_state_nx_s = wr_state_r;
    aw_lat_nx_s   = aw_lat_r;
    aw_idx_nx_s   = aw_idx_r;
    w_lat_nx_s    = w_lat_r;
    w_data_nx_s   = w_data_r;
    w_strb_nx_s   = w_strb_r;
    bvalid_nx_s   = bvalid_r;
    bresp_nx_s    = bresp_r;
    commit_s      = 1'b0;
    case (wr_state_r)
      WR_IDLE: begin
        if (aw_lat_r && w_lat_r) begin
          commit_s      = 1'b1;
          aw_lat_nx_s   = 1'b0;
          w_lat_nx_s    = 1'b0;
          bvalid_nx_s   = 1'b1;
          bresp_nx_s    = wr_in_range_s ? OKAY : SLVERR;
          wr_state_nx_s = WR_RESP;
        end else begin
          if (aw_hs_s) begin
            aw_lat_nx_s = 1'b1;
            aw_idx_nx_s = S_AXI_AWADDR[ADDR_W-1:ADDR_LSB];
          end else begin
            aw_lat_nx_s = aw_lat_r;
          end
          if (w_hs_s) begin
            w_lat_nx_s  = 1'b1;
            w_data_nx_s = S_AXI_WDATA;
            w_strb_nx_s = S_AXI_WSTRB;
          end else begin
            w_lat_nx_s = w_lat_r;
          end
        end
      end
      WR_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_nx_s   = 1'b0;
          wr_state_nx_s = WR_IDLE;
        end else begin
          bvalid_nx_s = 1'b1;
        end
      end
      default: begin
        wr_state_nx_s = WR_IDLE;
        bvalid_nx_s   = 1'b0;
      end
    endcase
    awready_nx_s = (wr_state_nx_s == WR_IDLE) && !aw_lat_nx_s;
    wready_nx_s  = (wr_state_nx_s == WR_IDLE) && !w_lat_nx_s;
  end

  // Read FSM: capture data on the AR handshake and hold it until RREADY.
  always_comb begin
    rd_state_nx_s = rd_state_r;
    rvalid_nx_s   = rvalid_r;
    rresp_nx_s    = rresp_r;
    rdata_nx_s    = rdata_r;
    case (rd_state_r)
      RD_IDLE: begin
        if (ar_hs_s) begin
          rvalid_nx_s   = 1'b1;
          rresp_nx_s    = rd_in_range_s ? OKAY : SLVERR;
          rdata_nx_s    = rd_in_range_s ? bank_rd_data_s : '0;
          rd_state_nx_s = RD_DATA;
        end else begin
          rvalid_nx_s = 1'b0;
        end
      end
      RD_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_nx_s   = 1'b0;
          rd_state_nx_s = RD_IDLE;
        end else begin
          rvalid_nx_s = 1'b1;
        end
      end
      default: begin
        rd_state_nx_s = RD_IDLE;
        rvalid_nx_s   = 1'b0;
      end
    endcase
    arready_nx_s = (rd_state_nx_s == RD_IDLE);
  end

  // State and output registers for both channels.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_r <= WR_IDLE;
      aw_lat_r   <= 1'b0;
      aw_idx_r   <= '0;
      w_lat_r    <= 1'b0;
      w_data_r   <= '0;
      w_strb_r   <= '0;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= OKAY;
      rd_state_r <= RD_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rresp_r    <= OKAY;
      rdata_r    <= '0;
    end else begin
      wr_state_r <= wr_state_nx_s;
      aw_lat_r   <= aw_lat_nx_s;
      aw_idx_r   <= aw_idx_nx_s;
      w_lat_r    <= w_lat_nx_s;
      w_data_r   <= w_data_nx_s;
      w_strb_r   <= w_strb_nx_s;
      awready_r  <= awready_nx_s;
      wready_r   <= wready_nx_s;
      bvalid_r   <= bvalid_nx_s;
      bresp_r    <= bresp_nx_s;
      rd_state_r <= rd_state_nx_s;
      arready_r  <= arready_nx_s;
      rvalid_r   <= rvalid_nx_s;
      rresp_r    <= rresp_nx_s;
      rdata_r    <= rdata_nx_s;
    end
  end

  axi4lite_reg_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk      (ACLK),
    .rst      (ARESET),
    .wr_en    (commit_s),
    .wr_idx   (aw_idx_r),
    .wr_data  (w_data_r),
    .wr_strb  (w_strb_r),
    .rd_idx   (rd_idx_s),
    .rd_data  (bank_rd_data_s),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RDATA   = rdata_r;

endmodule

// File: tb/tb_axi4lite_reg_responder.sv
// Directed self-checking bench for axi4lite_reg_responder (ADDR_W=5 so 0x10 is reachable).
module tb_axi4lite_reg_responder;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 4;

  logic                       ACLK = 1'b0;
  logic                       ARESET;
  logic [ADDR_W-1:0]          S_AXI_AWADDR;
  logic [2:0]                 S_AXI_AWPROT;
  logic                       S_AXI_AWVALID;
  logic                       S_AXI_AWREADY;
  logic [DATA_W-1:0]          S_AXI_WDATA;
  logic [DATA_W/8-1:0]        S_AXI_WSTRB;
  logic                       S_AXI_WVALID;
  logic                       S_AXI_WREADY;
  logic [1:0]                 S_AXI_BRESP;
  logic                       S_AXI_BVALID;
  logic                       S_AXI_BREADY;
  logic [ADDR_W-1:0]          S_AXI_ARADDR;
  logic [2:0]                 S_AXI_ARPROT;
  logic                       S_AXI_ARVALID;
  logic                       S_AXI_ARREADY;
  logic [DATA_W-1:0]          S_AXI_RDATA;
  logic [1:0]                 S_AXI_RRESP;
  logic                       S_AXI_RVALID;
  logic                       S_AXI_RREADY;
  logic [NUM_REGS*DATA_W-1:0] reg_q;
  logic [NUM_REGS-1:0]        wr_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt [NUM_REGS] = '{default: 0};

  axi4lite_reg_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  // Count write pulses away from the active edge.
  always @(negedge ACLK) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_pulse[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          output logic [1:0] resp);
    bit aw_done, w_done, b_done, aw_fire, w_fire, b_fire;
    aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    for (int k = 0; k < 40 && !(aw_done && w_done); k++) begin
      if (k == aw_dly) S_AXI_AWVALID = 1'b1;
      if (k == w_dly)  S_AXI_WVALID  = 1'b1;
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_fire) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_fire)  begin S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
    end
    chk("wr_accept", {aw_done, w_done}, 2'b11);
    S_AXI_BREADY = 1'b1;
    resp = 2'bxx;
    for (int k = 0; k < 40 && !b_done; k++) begin
      b_fire = S_AXI_BVALID;
      if (b_fire) resp = S_AXI_BRESP;
      tick();
      if (b_fire) b_done = 1'b1;
    end
    S_AXI_BREADY = 1'b0;
    chk("wr_b_seen", b_done, 1'b1);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    bit ar_done, r_done, ar_fire, r_fire;
    ar_done = 1'b0; r_done = 1'b0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    for (int k = 0; k < 40 && !ar_done; k++) begin
      ar_fire = S_AXI_ARREADY;
      tick();
      if (ar_fire) begin S_AXI_ARVALID = 1'b0; ar_done = 1'b1; end
    end
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    data = 32'hxxxxxxxx; resp = 2'bxx;
    for (int k = 0; k < 40 && !r_done; k++) begin
      r_fire = S_AXI_RVALID;
      if (r_fire) begin data = S_AXI_RDATA; resp = S_AXI_RRESP; end
      tick();
      if (r_fire) r_done = 1'b1;
    end
    S_AXI_RREADY = 1'b0;
    chk("rd_r_seen", {ar_done, r_done}, 2'b11);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;

    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = 3'b000; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = 4'b0000; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'b000; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    chk("rst_valid", {S_AXI_BVALID, S_AXI_RVALID, wr_pulse}, 6'b000000);
    chk("rst_resp_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 36'h0);
    chk("rst_reg_q", reg_q, 128'h0);
    ARESET = 1'b0;
    tick();
    chk("ready_after_rst", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    // T1: four writes then four reads
    for (int i = 0; i < 4; i++) begin
      do_write(5'(4 * i), 32'(i + 1), 4'b1111, 0, 0, resp);
      chk("t1_bresp", resp, 2'b00);
    end
    chk("t1_reg_q", reg_q, 128'h00000004_00000003_00000002_00000001);
    for (int i = 0; i < 4; i++) begin
      do_read(5'(4 * i), rdata, resp);
      chk("t1_rdata", rdata, 32'(i + 1));
      chk("t1_rresp", resp, 2'b00);
    end
    chk("t1_pulses", {pulse_cnt[3][7:0], pulse_cnt[2][7:0], pulse_cnt[1][7:0], pulse_cnt[0][7:0]},
        32'h01010101);

    // T2: W leads AW by three cycles, one byte lane
    do_write(5'h00, 32'h11111111, 4'b1111, 0, 0, resp);
    do_write(5'h00, 32'hAABBCCDD, 4'b0010, 3, 0, resp);
    chk("t2_bresp", resp, 2'b00);
    chk("t2_reg0", reg_q[31:0], 32'h1111CC11);
    tick();
    chk("t2_single_b", S_AXI_BVALID, 1'b0);
    chk("t2_pulse0", pulse_cnt[0], 3);

    // T3: out-of-range write and read
    do_write(5'h10, 32'hDEADBEEF, 4'b1111, 0, 0, resp);
    chk("t3_bresp", resp, 2'b10);
    chk("t3_reg_q", reg_q, 128'h00000004_00000003_00000002_1111CC11);
    chk("t3_no_pulse", {pulse_cnt[3][7:0], pulse_cnt[2][7:0], pulse_cnt[1][7:0], pulse_cnt[0][7:0]},
        32'h01010103);
    do_read(5'h10, rdata, resp);
    chk("t3_rdata", rdata, 32'h0);
    chk("t3_rresp", resp, 2'b10);

    // T4: stall B and R for ten cycles
    S_AXI_AWADDR = 5'h08; S_AXI_WDATA = 32'h00000033; S_AXI_WSTRB = 4'b1111;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("t4_stall_ctl", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY,
                           S_AXI_ARREADY, S_AXI_RVALID}, 7'b1000001);
      chk("t4_stall_rdata", {S_AXI_RRESP, S_AXI_RDATA}, 34'h000000004);
      tick();
    end
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    chk("t4_release", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY}, 4'b0011);
    chk("t4_reg2", reg_q[95:64], 32'h00000033);

    // T5: read and write commit to reg1 on the same edge
    do_write(5'h04, 32'h00000005, 4'b1111, 0, 0, resp);
    S_AXI_AWADDR = 5'h04; S_AXI_WDATA = 32'h00000009; S_AXI_WSTRB = 4'b1111;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 5'h04; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    chk("t5_rvalid_bvalid", {S_AXI_RVALID, S_AXI_BVALID}, 2'b11);
    chk("t5_old_value", S_AXI_RDATA, 32'h00000005);
    chk("t5_reg1_new", reg_q[63:32], 32'h00000009);
    chk("t5_pulse", wr_pulse, 4'b0010);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    do_read(5'h04, rdata, resp);
    chk("t5_second_read", rdata, 32'h00000009);

    // T6: reset while BVALID is high
    S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h00000077; S_AXI_WSTRB = 4'b1111;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tick();
    chk("t6_bvalid_before", S_AXI_BVALID, 1'b1);
    chk("t6_reg3_before", reg_q[127:96], 32'h00000077);
    ARESET = 1'b1;
    #1;
    chk("t6_bvalid_cleared", S_AXI_BVALID, 1'b0);
    chk("t6_reg_q_cleared", reg_q, 128'h0);
    #2;
    ARESET = 1'b0;
    tick();
    chk("t6_ready_again", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    do_write(5'h08, 32'hCAFEF00D, 4'b1111, 0, 0, resp);
    chk("t6_bresp", resp, 2'b00);
    chk("t6_reg_q", reg_q, 128'h00000000_CAFEF00D_00000000_00000000);
    do_read(5'h08, rdata, resp);
    chk("t6_rdata", {resp, rdata}, 34'h0CAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
